// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : Time-multiplexed seven-segment scan controller with per-slot
//           blanking, hex decode and frame-boundary double buffering.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   digits_in,
  input  logic [NDIG-1:0]     dp_in,
  input  logic [NDIG-1:0]     dig_mask,
  output logic [NDIG-1:0]     anode,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic                frame_done
);

  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_idx_w = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(NDIG - 1);
  localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
  localparam logic [6:0]         c_seg_off   = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  // With no blanking interval every slot starts directly in DRIVE.
  localparam state_t c_slot_start = (BLANK_CYC > 0) ? S_BLANK : S_DRIVE;

  function automatic logic [6:0] f_hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_idx_w-1:0]   w_idx_nxt;
  logic                 w_frame_end;
  logic                 w_swap;

  logic [4*NDIG-1:0]    r_pend_dig;
  logic [NDIG-1:0]      r_pend_dp;
  logic                 r_pend_v;
  logic [4*NDIG-1:0]    r_shd_dig;
  logic [NDIG-1:0]      r_shd_dp;
  logic [4*NDIG-1:0]    w_shd_dig_nxt;
  logic [NDIG-1:0]      w_shd_dp_nxt;

  logic [3:0]           w_nib;
  logic                 w_dp;
  logic                 w_msk;
  logic [NDIG-1:0]      w_an_sel;

  logic [NDIG-1:0]      r_anode;
  logic [6:0]           r_seg;
  logic                 r_dp_n;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_frame_end = 1'b0;
    w_swap      = 1'b0;
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = c_slot_start;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_swap      = 1'b1;
        end
        S_BLANK: begin
          w_cnt_nxt = r_cnt + c_cnt_one;
          if (r_cnt == c_blank_last) begin
            w_state_nxt = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt == c_cnt_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = c_slot_start;
            if (r_idx == c_idx_last) begin
              w_idx_nxt   = '0;
              w_frame_end = 1'b1;
              w_swap      = 1'b1;
            end else begin
              w_idx_nxt = r_idx + c_idx_one;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // A load landing on a swap edge bypasses the pending buffer entirely.
  always_comb begin
    w_shd_dig_nxt = r_shd_dig;
    w_shd_dp_nxt  = r_shd_dp;
    if (w_swap) begin
      if (load) begin
        w_shd_dig_nxt = digits_in;
        w_shd_dp_nxt  = dp_in;
      end else if (r_pend_v) begin
        w_shd_dig_nxt = r_pend_dig;
        w_shd_dp_nxt  = r_pend_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_pend_dig <= '0;
      r_pend_dp  <= '0;
      r_pend_v   <= 1'b0;
      r_shd_dig  <= '0;
      r_shd_dp   <= '0;
    end else begin
      if (load) begin
        r_pend_dig <= digits_in;
        r_pend_dp  <= dp_in;
      end
      if (w_swap) begin
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend_v <= 1'b1;
      end
      r_shd_dig <= w_shd_dig_nxt;
      r_shd_dp  <= w_shd_dp_nxt;
    end
  end

  // Outputs are registered from next-state values so they track the FSM edge.
  always_comb begin
    w_nib    = '0;
    w_dp     = 1'b0;
    w_msk    = 1'b0;
    w_an_sel = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (w_idx_nxt == c_idx_w'(i)) begin
        w_nib       = w_shd_dig_nxt[4*i +: 4];
        w_dp        = w_shd_dp_nxt[i];
        w_msk       = dig_mask[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_anode <= '1;
      r_seg   <= c_seg_off;
      r_dp_n  <= 1'b1;
    end else if ((w_state_nxt == S_DRIVE) && w_msk) begin
      r_anode <= w_an_sel;
      r_seg   <= f_hex7(w_nib);
      r_dp_n  <= ~w_dp;
    end else begin
      r_anode <= '1;
      r_seg   <= c_seg_off;
      r_dp_n  <= 1'b1;
    end
  end

  assign anode      = r_anode;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_done = w_frame_end & ~arst;

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the seven-segment display. It owns the display's digit sequencing:
- steps through NDIG digits with a programmable slot length;
- inserts a blanking interval at the start of every slot to suppress ghosting;
- decodes hex nibbles to active-low segments;
- double-buffers display data so updates land only on frame boundaries.

It replaces per-rate divided clocks with an internal slot counter in the single system clock domain.

## Interface
- NDIG, 4: number of digits scanned, 1 to 8.
- TICK_DIV, 50000: clock cycles per digit slot; must be at least 2.
- BLANK_CYC, 8: blanked cycles at the start of each slot; must satisfy 0 ≤ BLANK_CYC < TICK_DIV.

- clk  in  1  system clock; one clock domain only.
- arst  in  1  reset; synchronous, active-high.
- en  in  1  scan enable; when low, the display is blanked and idle.
- load  in  1  one-cycle strobe that captures digits_in and dp_in into the pending buffer.
- digits_in  in  4*NDIG  hex nibble per digit; digit i uses bits [4i+3:4i].
- dp_in  in  NDIG  decimal point per digit; 1 means lit.
- dig_mask  in  NDIG  1 enables digit i; sampled live each cycle, not buffered.
- anode  out  NDIG  active-low digit select.
- seg  out  7  active-low segments; seg[0]=a through seg[6]=g.
- dp_n  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- States:
  - IDLE: all outputs blanked.
  - BLANK: slot counter cnt is in 0 to BLANK_CYC-1.
  - DRIVE: cnt is in BLANK_CYC to TICK_DIV-1.
- Counters and buffers:
  - cnt: $clog2(TICK_DIV) bits.
  - idx: digit index, wraps from NDIG-1 to 0.
  - pending buffer, with a pend_v flag.
  - shadow buffer, which drives the display.
- IDLE to BLANK: when en=1 is sampled.
  - idx and cnt are set to 0.
  - If pend_v=1, the shadow buffer takes the pending buffer and pend_v clears.
- BLANK to DRIVE: when cnt reaches BLANK_CYC-1. If BLANK_CYC=0, BLANK is skipped.
- End of slot, when cnt=TICK_DIV-1:
  - cnt returns to 0 and the next state is BLANK.
  - If idx=NDIG-1:
    - idx becomes 0 and frame_done=1 in this cycle.
    - If pend_v=1, the shadow buffer takes the pending buffer and pend_v clears.
  - Otherwise idx increments.
- en=0 in any state: the next state is IDLE, with cnt=0 and idx=0. frame_done is not pulsed. pend_v is preserved.
- Load handling:
  - load=1 writes digits_in and dp_in into the pending buffer and sets pend_v.
  - Successive loads overwrite; the last one wins.
  - If load coincides with a frame boundary or with IDLE exit, the shadow buffer takes digits_in and dp_in directly and pend_v stays 0.
- Output drive:
  - In DRIVE with dig_mask[idx]=1: anode has only bit idx low; seg is the decoded shadow nibble; dp_n is the inverse of shadow dp[idx].
  - In DRIVE with dig_mask[idx]=0: anode is all ones, seg=7'h7F, dp_n=1. The slot is still consumed, so frame length is constant.
  - In BLANK and IDLE: anode is all ones, seg=7'h7F, dp_n=1.
- Hex decode (active-low, seg[6:0]=gfedcba), complete over all 16 codes:

  | Digit | seg   | Digit | seg   |
  |-------|-------|-------|-------|
  | 0     | 7'h40 | 8     | 7'h00 |
  | 1     | 7'h79 | 9     | 7'h10 |
  | 2     | 7'h24 | A     | 7'h08 |
  | 3     | 7'h30 | b     | 7'h03 |
  | 4     | 7'h19 | C     | 7'h46 |
  | 5     | 7'h12 | d     | 7'h21 |
  | 6     | 7'h02 | E     | 7'h06 |
  | 7     | 7'h78 | F     | 7'h0E |

## Timing
- Reset values, all synchronous:
  - state IDLE, cnt=0, idx=0;
  - pending buffer 0, shadow buffer 0, pend_v=0;
  - anode all ones, seg=7'h7F, dp_n=1, frame_done=0.
- arst has priority over en and load in the same cycle. Reset mid-frame blanks the outputs on the next edge.
- anode, seg and dp_n are flops, so outputs are glitch-free. They are loaded from next-state and next-idx, so outputs change on the same edge as the state register.
- Latency from en=1 sampled at edge k:
  - first blanked cycle of slot 0 at k+1;
  - first driven cycle at k+1+BLANK_CYC.
- Periods:
  - slot period is TICK_DIV cycles exactly;
  - frame period is NDIG×TICK_DIV cycles;
  - frame_done period equals the frame period.
- A load takes effect on the display at the first frame boundary after the load cycle, at most NDIG×TICK_DIV cycles later.
- There are never two anode bits low in the same cycle.

## Test plan
All scenarios use NDIG=4, TICK_DIV=10, BLANK_CYC=2.
1. Reset: arst=1 for 2 cycles with en=1 and load=1 → anode=4'hF, seg=7'h7F, dp_n=1, frame_done=0, pend_v=0. The first slot starts only after arst falls.
2. Basic scan: load digits_in=16'h1234 and dp_in=4'b0001 in the same cycle as en=1.
   - Slot 0: 2 cycles blank, then 8 cycles with anode=4'b1110, seg=7'h19, dp_n=0.
   - Slot 1: seg=7'h30. Slot 2: seg=7'h24. Slot 3: seg=7'h79.
   - frame_done is high at cycle 40 and cycle 80 only.
3. Deferred update: during slot 1, load 16'hFFFF → the remaining slots still show 3, 2, 1. After the frame_done cycle all digits show seg=7'h0E. A second load before the boundary overrides the first.
4. Mask: dig_mask=4'b1011 → slot 2 keeps anode=4'hF and seg=7'h7F for all 10 cycles. Frame period stays 40 cycles.
5. Enable drop: en=0 at cycle 5 of slot 1 DRIVE → the next cycle is blanked and frame_done does not pulse. Re-enable → restart at idx 0 with a 2-cycle blank.
6. Reset mid-frame: arst=1 during slot 2 DRIVE → the next cycle is blanked with idx=0 and the shadow buffer cleared. With en=1 held, the scan resumes displaying 0000 (seg=7'h40).
